// File: rtl/load_store_unit.sv
// Load/store unit: aligns, byte-enables and sign/zero-extends RISC-V loads and stores onto a word-wide memory port with ack watchdog.
// Define LSU_MISALIGNED_SPLIT_EN to perform misaligned accesses (two beats when they cross a word) instead of faulting them.
module load_store_unit #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_store,
    input  logic [2:0]          req_funct3,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                done,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          fault,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata
);
    localparam int NB     = DATA_W / 8;
    localparam int OFS    = $clog2(NB);
    localparam int WD_W   = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) + 1 : 1;
    localparam int WD_LIM = (MAX_WAIT > 0) ? MAX_WAIT - 1 : 0;

    typedef enum logic [1:0] {S_IDLE, S_ACC1, S_ACC2, S_DONE} state_t;

    state_t              state_q, state_d;
    logic                store_q, store_d;
    logic [2:0]          f3_q, f3_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          fault_q, fault_d;

    logic                req_legal;
    int                  o_i;
    int                  sz_i;
    logic [ADDR_W-1:0]   word_addr;
    logic [NB-1:0]       be1;
    logic [DATA_W-1:0]   wd1;
    logic [DATA_W-1:0]   first_w;
    logic [DATA_W-1:0]   raw;
    logic [DATA_W-1:0]   ext;
    logic                sgn;

    // Stores only take B/H/W(/D); loads additionally take the unsigned codes.
    function automatic logic legal_f3(input logic st, input logic [2:0] f3);
        logic ok;
        if (st)
            ok = !f3[2] && ((f3[1:0] != 2'b11) || (DATA_W == 64));
        else if (!f3[2])
            ok = (f3[1:0] != 2'b11) || (DATA_W == 64);
        else
            ok = (f3[1:0] == 2'b00) || (f3[1:0] == 2'b01) ||
                 ((f3[1:0] == 2'b10) && (DATA_W == 64));
        return ok;
    endfunction

    assign req_legal = legal_f3(req_store, req_funct3);
    assign o_i       = int'(addr_q[OFS-1:0]);
    assign sz_i      = 1 << f3_q[1:0];
    assign word_addr = {addr_q[ADDR_W-1:OFS], {OFS{1'b0}}};

`ifdef LSU_MISALIGNED_SPLIT_EN
    logic [DATA_W-1:0] lo_q, lo_d;
    logic              cross;
    logic [NB-1:0]     be2;
    logic [DATA_W-1:0] wd2;

    assign cross   = (o_i + sz_i) > NB;
    assign first_w = (state_q == S_ACC2) ? lo_q : mem_rdata;

    // Second beat carries the lanes that spilled past the top of the first word.
    always_comb begin
        be2 = '0;
        wd2 = '0;
        for (int i = 0; i < NB; i++) begin
            if (i + NB < o_i + sz_i) be2[i] = 1'b1;
            for (int j = 0; j < NB; j++)
                if (i + NB == j + o_i) wd2[8*i +: 8] = wdata_q[8*j +: 8];
        end
    end
`else
    logic [OFS-1:0] req_amask;
    logic           req_mis;

    assign req_amask = OFS'((1 << req_funct3[1:0]) - 1);
    assign req_mis   = |(req_addr[OFS-1:0] & req_amask);
    assign first_w   = mem_rdata;
`endif

    always_comb begin
        be1 = '0;
        wd1 = '0;
        for (int i = 0; i < NB; i++) begin
            if ((i >= o_i) && (i < o_i + sz_i)) be1[i] = 1'b1;
            for (int j = 0; j < NB; j++)
                if (i == j + o_i) wd1[8*i +: 8] = wdata_q[8*j +: 8];
        end
    end

    // Byte b of the result comes from lane o+b, wrapping into the second beat.
    always_comb begin
        raw = '0;
        for (int b = 0; b < NB; b++) begin
            for (int j = 0; j < NB; j++) begin
                if (j == b + o_i) raw[8*b +: 8] = first_w[8*j +: 8];
`ifdef LSU_MISALIGNED_SPLIT_EN
                if (j + NB == b + o_i) raw[8*b +: 8] = mem_rdata[8*j +: 8];
`endif
            end
        end
    end

    always_comb begin
        ext = raw;
        sgn = 1'b0;
        for (int b = 0; b < NB; b++)
            if (b == sz_i - 1) sgn = raw[8*b+7];
        if (f3_q[2]) sgn = 1'b0;
        for (int b = 0; b < NB; b++)
            if (b >= sz_i) ext[8*b +: 8] = {8{sgn}};
    end

    always_comb begin
        state_d   = state_q;
        store_d   = store_q;
        f3_d      = f3_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wd_d      = wd_q;
        rdata_d   = rdata_q;
        fault_d   = fault_q;
`ifdef LSU_MISALIGNED_SPLIT_EN
        lo_d      = lo_q;
`endif
        req_ready = 1'b0;
        done      = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = '0;
        mem_wdata = '0;
        unique case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    store_d = req_store;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wd_d    = '0;
                    if (!req_legal) begin
                        fault_d = 2'b11;
                        state_d = S_DONE;
                    end
`ifndef LSU_MISALIGNED_SPLIT_EN
                    else if (req_mis) begin
                        fault_d = 2'b01;
                        state_d = S_DONE;
                    end
`endif
                    else begin
                        state_d = S_ACC1;
                    end
                end
            end
            S_ACC1: begin
                mem_req   = 1'b1;
                mem_we    = store_q;
                mem_addr  = word_addr;
                mem_be    = be1;
                mem_wdata = wd1;
                if (mem_ack) begin
                    wd_d = '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
                    if (cross) begin
                        lo_d    = mem_rdata;
                        state_d = S_ACC2;
                    end else
`endif
                    begin
                        fault_d = 2'b00;
                        state_d = S_DONE;
                        if (!store_q) rdata_d = ext;
                    end
                end else if (MAX_WAIT > 0) begin
                    if (wd_q == WD_W'(WD_LIM)) begin
                        fault_d = 2'b10;
                        state_d = S_DONE;
                    end else begin
                        wd_d = wd_q + 1'b1;
                    end
                end
            end
`ifdef LSU_MISALIGNED_SPLIT_EN
            S_ACC2: begin
                mem_req   = 1'b1;
                mem_we    = store_q;
                mem_addr  = word_addr + ADDR_W'(NB);
                mem_be    = be2;
                mem_wdata = wd2;
                if (mem_ack) begin
                    wd_d    = '0;
                    fault_d = 2'b00;
                    state_d = S_DONE;
                    if (!store_q) rdata_d = ext;
                end else if (MAX_WAIT > 0) begin
                    if (wd_q == WD_W'(WD_LIM)) begin
                        fault_d = 2'b10;
                        state_d = S_DONE;
                    end else begin
                        wd_d = wd_q + 1'b1;
                    end
                end
            end
`endif
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            store_q <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wd_q    <= '0;
            rdata_q <= '0;
            fault_q <= 2'b00;
`ifdef LSU_MISALIGNED_SPLIT_EN
            lo_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            store_q <= store_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wd_q    <= wd_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
`ifdef LSU_MISALIGNED_SPLIT_EN
            lo_q    <= lo_d;
`endif
        end
    end

    assign rdata = rdata_q;
    assign fault = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench: a 32-bit LSU (watchdog 16) and a 64-bit LSU (watchdog 4), checked against hand-computed values.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        reset;
    int          vec_cnt = 0;
    int          miss_cnt = 0;
    logic [31:0] last_rd;

    logic        req_valid, req_ready, req_store, done, mem_req, mem_we, mem_ack;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata, rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  fault;
    logic [3:0]  mem_be;

    logic        w_req_valid, w_req_ready, w_req_store, w_done, w_mem_req, w_mem_we, w_mem_ack;
    logic [2:0]  w_req_funct3;
    logic [31:0] w_req_addr, w_mem_addr;
    logic [63:0] w_req_wdata, w_rdata, w_mem_wdata, w_mem_rdata;
    logic [1:0]  w_fault;
    logic [7:0]  w_mem_be;

    always #5 clk = ~clk;

    load_store_unit #(.DATA_W(32), .ADDR_W(32), .MAX_WAIT(16)) u32 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .done(done), .rdata(rdata), .fault(fault),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    load_store_unit #(.DATA_W(64), .ADDR_W(32), .MAX_WAIT(4)) u64 (
        .clk(clk), .reset(reset), .req_valid(w_req_valid), .req_ready(w_req_ready),
        .req_store(w_req_store), .req_funct3(w_req_funct3), .req_addr(w_req_addr),
        .req_wdata(w_req_wdata), .done(w_done), .rdata(w_rdata), .fault(w_fault),
        .mem_req(w_mem_req), .mem_we(w_mem_we), .mem_addr(w_mem_addr), .mem_be(w_mem_be),
        .mem_wdata(w_mem_wdata), .mem_ack(w_mem_ack), .mem_rdata(w_mem_rdata)
    );

    // Called on a negedge; returns on the negedge after the accept edge.
    task automatic start32(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic start64(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [63:0] wd);
        w_req_valid = 1'b1; w_req_store = st; w_req_funct3 = f3; w_req_addr = a; w_req_wdata = wd;
        @(negedge clk);
        w_req_valid = 1'b0;
    endtask

    task automatic test_reset();
        vec_cnt++; if (req_ready !== 1'b1) begin miss_cnt++; $display("FAIL rst_ready: got %b want 1", req_ready); end
        vec_cnt++; if (done !== 1'b0) begin miss_cnt++; $display("FAIL rst_done: got %b want 0", done); end
        vec_cnt++; if (fault !== 2'b00) begin miss_cnt++; $display("FAIL rst_fault: got %b want 00", fault); end
        vec_cnt++; if (rdata !== 32'h0) begin miss_cnt++; $display("FAIL rst_rdata: got %h want 0", rdata); end
        vec_cnt++; if ({mem_req, mem_we} !== 2'b00) begin miss_cnt++; $display("FAIL rst_memreq: got %b want 00", {mem_req, mem_we}); end
        vec_cnt++; if ({mem_addr, mem_be, mem_wdata} !== 68'h0) begin miss_cnt++; $display("FAIL rst_membus: got %h want 0", {mem_addr, mem_be, mem_wdata}); end
        vec_cnt++; if ({w_req_ready, w_mem_req, w_done} !== 3'b100) begin miss_cnt++; $display("FAIL rst_w_ctl: got %b want 100", {w_req_ready, w_mem_req, w_done}); end
        vec_cnt++; if (w_rdata !== 64'h0) begin miss_cnt++; $display("FAIL rst_w_rdata: got %h want 0", w_rdata); end
    endtask

    task automatic test_load_byte();
        start32(1'b0, 3'b000, 32'h103, 32'h0);
        vec_cnt++; if ({mem_req, mem_we, req_ready, done} !== 4'b1000) begin miss_cnt++; $display("FAIL lb_ctl: got %b want 1000", {mem_req, mem_we, req_ready, done}); end
        vec_cnt++; if (mem_addr !== 32'h100) begin miss_cnt++; $display("FAIL lb_addr: got %h want 100", mem_addr); end
        vec_cnt++; if (mem_be !== 4'b1000) begin miss_cnt++; $display("FAIL lb_be: got %b want 1000", mem_be); end
        mem_ack = 1'b1; mem_rdata = 32'h80FF_1234;
        @(negedge clk);
        mem_ack = 1'b0;
        vec_cnt++; if ({done, mem_req} !== 2'b10) begin miss_cnt++; $display("FAIL lb_done: got %b want 10", {done, mem_req}); end
        vec_cnt++; if (rdata !== 32'hFFFF_FF80) begin miss_cnt++; $display("FAIL lb_rdata: got %h want ffffff80", rdata); end
        vec_cnt++; if (fault !== 2'b00) begin miss_cnt++; $display("FAIL lb_fault: got %b want 00", fault); end
        @(negedge clk);
        vec_cnt++; if ({done, req_ready} !== 2'b01) begin miss_cnt++; $display("FAIL lb_idle: got %b want 01", {done, req_ready}); end
        last_rd = 32'hFFFF_FF80;
    endtask

    task automatic test_store_wait();
        start32(1'b1, 3'b001, 32'h202, 32'h0000_ABCD);
        for (int k = 0; k < 5; k++) begin
            vec_cnt++;
            if ({mem_req, mem_we, done} !== 3'b110 || mem_addr !== 32'h200 || mem_be !== 4'b1100 || mem_wdata !== 32'hABCD_0000) begin
                miss_cnt++;
                $display("FAIL sh_hold%0d: got req/we/done=%b addr=%h be=%b wdata=%h want 110 200 1100 abcd0000", k, {mem_req, mem_we, done}, mem_addr, mem_be, mem_wdata);
            end
            if (k < 4) @(negedge clk);
        end
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        vec_cnt++; if ({done, mem_req, fault} !== 4'b1000) begin miss_cnt++; $display("FAIL sh_done: got %b want 1000", {done, mem_req, fault}); end
        vec_cnt++; if (rdata !== last_rd) begin miss_cnt++; $display("FAIL sh_rdata_kept: got %h want %h", rdata, last_rd); end
        @(negedge clk);
    endtask

    // Back-to-back aligned loads of one memory word: funct3, addr, be, expected result.
    task automatic test_extend();
        logic [2:0]  f3s [5] = '{3'b001, 3'b101, 3'b100, 3'b010, 3'b000};
        logic [31:0] ads [5] = '{32'h102, 32'h102, 32'h101, 32'h100, 32'h100};
        logic [3:0]  bes [5] = '{4'b1100, 4'b1100, 4'b0010, 4'b1111, 4'b0001};
        logic [31:0] exs [5] = '{32'hFFFF_80FF, 32'h0000_80FF, 32'h0000_0012, 32'h80FF_1234, 32'h0000_0034};
        for (int i = 0; i < 5; i++) begin
            start32(1'b0, f3s[i], ads[i], 32'h0);
            vec_cnt++; if (mem_be !== bes[i]) begin miss_cnt++; $display("FAIL ext%0d_be: got %b want %b", i, mem_be, bes[i]); end
            mem_ack = 1'b1; mem_rdata = 32'h80FF_1234;
            @(negedge clk);
            mem_ack = 1'b0;
            vec_cnt++; if (done !== 1'b1 || rdata !== exs[i]) begin miss_cnt++; $display("FAIL ext%0d_rdata: got done=%b %h want 1 %h", i, done, rdata, exs[i]); end
            @(negedge clk);
        end
        last_rd = 32'h0000_0034;
    endtask

    task automatic test_misaligned();
`ifdef LSU_MISALIGNED_SPLIT_EN
        start32(1'b0, 3'b010, 32'h301, 32'h0);
        vec_cnt++; if (mem_req !== 1'b1 || mem_addr !== 32'h300 || mem_be !== 4'b1110) begin miss_cnt++; $display("FAIL lw_beat1: got req=%b addr=%h be=%b want 1 300 1110", mem_req, mem_addr, mem_be); end
        mem_ack = 1'b1; mem_rdata = 32'h4433_2211;
        @(negedge clk);
        vec_cnt++; if ({mem_req, done} !== 2'b10 || mem_addr !== 32'h304 || mem_be !== 4'b0001) begin miss_cnt++; $display("FAIL lw_beat2: got req/done=%b addr=%h be=%b want 10 304 0001", {mem_req, done}, mem_addr, mem_be); end
        mem_rdata = 32'h8877_6655;
        @(negedge clk);
        mem_ack = 1'b0;
        vec_cnt++; if ({done, fault} !== 3'b100 || rdata !== 32'h5544_3322) begin miss_cnt++; $display("FAIL lw_split_rdata: got done/fault=%b %h want 100 55443322", {done, fault}, rdata); end
        @(negedge clk);
        start32(1'b0, 3'b101, 32'h101, 32'h0);
        vec_cnt++; if (mem_be !== 4'b0110) begin miss_cnt++; $display("FAIL lhu_mis_be: got %b want 0110", mem_be); end
        mem_ack = 1'b1; mem_rdata = 32'h80FF_1234;
        @(negedge clk);
        mem_ack = 1'b0;
        vec_cnt++; if (done !== 1'b1 || rdata !== 32'h0000_FF12) begin miss_cnt++; $display("FAIL lhu_mis_rdata: got done=%b %h want 1 0000ff12", done, rdata); end
        @(negedge clk);
        start32(1'b1, 3'b010, 32'h302, 32'hDDCC_BBAA);
        vec_cnt++; if (mem_we !== 1'b1 || mem_be !== 4'b1100 || mem_wdata !== 32'hBBAA_0000) begin miss_cnt++; $display("FAIL sw_beat1: got we=%b be=%b wdata=%h want 1 1100 bbaa0000", mem_we, mem_be, mem_wdata); end
        mem_ack = 1'b1;
        @(negedge clk);
        vec_cnt++; if (mem_addr !== 32'h304 || mem_be !== 4'b0011 || mem_wdata !== 32'h0000_DDCC) begin miss_cnt++; $display("FAIL sw_beat2: got addr=%h be=%b wdata=%h want 304 0011 0000ddcc", mem_addr, mem_be, mem_wdata); end
        @(negedge clk);
        mem_ack = 1'b0;
        vec_cnt++; if ({done, fault} !== 3'b100 || rdata !== 32'h0000_FF12) begin miss_cnt++; $display("FAIL sw_split_done: got done/fault=%b %h want 100 0000ff12", {done, fault}, rdata); end
        @(negedge clk);
        last_rd = 32'h0000_FF12;
`else
        start32(1'b0, 3'b010, 32'h301, 32'h0);
        vec_cnt++; if ({done, mem_req, fault} !== 4'b1001) begin miss_cnt++; $display("FAIL lw_mis_fault: got done/req/fault=%b want 1001", {done, mem_req, fault}); end
        vec_cnt++; if (rdata !== last_rd) begin miss_cnt++; $display("FAIL lw_mis_rdata: got %h want %h", rdata, last_rd); end
        @(negedge clk);
        start32(1'b0, 3'b101, 32'h101, 32'h0);
        vec_cnt++; if ({done, mem_req, fault} !== 4'b1001) begin miss_cnt++; $display("FAIL lhu_mis_fault: got %b want 1001", {done, mem_req, fault}); end
        @(negedge clk);
        start32(1'b1, 3'b010, 32'h302, 32'hDDCC_BBAA);
        vec_cnt++; if ({done, mem_req, fault} !== 4'b1001) begin miss_cnt++; $display("FAIL sw_mis_fault: got %b want 1001", {done, mem_req, fault}); end
        @(negedge clk);
`endif
    endtask

    task automatic test_illegal();
        logic       sts [3] = '{1'b0, 1'b0, 1'b1};
        logic [2:0] f3s [3] = '{3'b011, 3'b110, 3'b100};
        for (int i = 0; i < 3; i++) begin
            start32(sts[i], f3s[i], 32'h0, 32'h0);
            vec_cnt++; if ({done, mem_req, fault} !== 4'b1011 || rdata !== last_rd) begin miss_cnt++; $display("FAIL illegal%0d: got done/req/fault=%b rdata=%h want 1011 %h", i, {done, mem_req, fault}, rdata, last_rd); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        start32(1'b0, 3'b010, 32'h500, 32'h0);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h600;
        @(negedge clk);
        req_valid = 1'b0;
        vec_cnt++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h500) begin miss_cnt++; $display("FAIL busy_drop: got req=%b we=%b addr=%h want 1 0 500", mem_req, mem_we, mem_addr); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vec_cnt++; if ({mem_req, req_ready, done} !== 3'b010 || rdata !== 32'h0) begin miss_cnt++; $display("FAIL rst_mid: got req/ready/done=%b rdata=%h want 010 0", {mem_req, req_ready, done}, rdata); end
        @(negedge clk);
        vec_cnt++; if ({mem_req, done} !== 2'b00) begin miss_cnt++; $display("FAIL rst_no_queue: got %b want 00", {mem_req, done}); end
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        vec_cnt++; if ({mem_req, done, req_ready} !== 3'b001) begin miss_cnt++; $display("FAIL idle_ack: got %b want 001", {mem_req, done, req_ready}); end
    endtask

    task automatic test_wide_load();
        logic [2:0]  f3s [3] = '{3'b110, 3'b010, 3'b011};
        logic [31:0] ads [3] = '{32'h4, 32'h4, 32'h8};
        logic [31:0] was [3] = '{32'h0, 32'h0, 32'h8};
        logic [7:0]  bes [3] = '{8'hF0, 8'hF0, 8'hFF};
        logic [63:0] rds [3] = '{64'hF000_0001_1234_5678, 64'hF000_0001_1234_5678, 64'h0123_4567_89AB_CDEF};
        logic [63:0] exs [3] = '{64'h0000_0000_F000_0001, 64'hFFFF_FFFF_F000_0001, 64'h0123_4567_89AB_CDEF};
        for (int i = 0; i < 3; i++) begin
            start64(1'b0, f3s[i], ads[i], 64'h0);
            vec_cnt++; if (w_mem_req !== 1'b1 || w_mem_addr !== was[i] || w_mem_be !== bes[i]) begin miss_cnt++; $display("FAIL w%0d_beat: got req=%b addr=%h be=%h want 1 %h %h", i, w_mem_req, w_mem_addr, w_mem_be, was[i], bes[i]); end
            w_mem_ack = 1'b1; w_mem_rdata = rds[i];
            @(negedge clk);
            w_mem_ack = 1'b0;
            vec_cnt++; if (w_done !== 1'b1 || w_rdata !== exs[i] || w_fault !== 2'b00) begin miss_cnt++; $display("FAIL w%0d_rdata: got done=%b fault=%b %h want 1 00 %h", i, w_done, w_fault, w_rdata, exs[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        start64(1'b0, 3'b010, 32'h10, 64'h0);
        for (int k = 0; k < 12; k++) begin
            if (w_done) break;
            if (w_mem_req) req_cycles++;
            @(negedge clk);
        end
        vec_cnt++; if (w_done !== 1'b1) begin miss_cnt++; $display("FAIL tmo_done: got %b want 1 within 12 cycles", w_done); end
        vec_cnt++; if (req_cycles != 4) begin miss_cnt++; $display("FAIL tmo_req_cycles: got %0d want 4", req_cycles); end
        vec_cnt++; if (w_fault !== 2'b10 || w_mem_req !== 1'b0) begin miss_cnt++; $display("FAIL tmo_fault: got fault=%b req=%b want 10 0", w_fault, w_mem_req); end
        vec_cnt++; if (w_rdata !== 64'h0123_4567_89AB_CDEF) begin miss_cnt++; $display("FAIL tmo_rdata_kept: got %h want 0123456789abcdef", w_rdata); end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b0; req_addr = '0; req_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        w_req_valid = 1'b0; w_req_store = 1'b0; w_req_funct3 = 3'b0; w_req_addr = '0; w_req_wdata = '0;
        w_mem_ack = 1'b0; w_mem_rdata = '0;
        last_rd = '0;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b0;
        @(negedge clk);
        test_load_byte();
        test_store_wait();
        test_extend();
        test_misaligned();
        test_illegal();
        test_reset_mid();
        test_wide_load();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Parametrised load/store unit between the core's ALU address/store-data path and a word-wide data memory port with wait states.
- Handles all RISC-V funct3 load/store widths: byte-lane alignment, sign/zero extension, byte enables, multi-cycle memory handshake, ack watchdog.
- Stalls the core through `req_ready` while a transaction is in flight.

Parameters:
- DATA_W, 32, memory/register width; 32 or 64. NB = DATA_W/8 byte lanes; OFS = log2(NB) offset bits.
- ADDR_W, 32, byte address width.
- MAX_WAIT, 16, cycles to wait for `mem_ack` before a bus error; 0 disables the watchdog.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  core request strobe; accepted only when req_ready=1.
- req_ready  out  1  high in IDLE only.
- req_store  in  1  1=store, 0=load.
- req_funct3  in  3  RISC-V funct3 width/sign code.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, LSB-justified.
- done  out  1  one-cycle completion pulse.
- rdata  out  DATA_W  extended load result; valid while done=1, held until the next done.
- fault  out  2  valid with done: 00 ok, 01 misaligned, 10 bus timeout, 11 illegal width.
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W  NB-aligned word address (low OFS bits = 0).
- mem_be  out  NB  byte enables.
- mem_wdata  out  DATA_W  lane-shifted store data.
- mem_ack  in  1  transfer complete in the current cycle.
- mem_rdata  in  DATA_W  read data; valid when mem_ack=1.

Behaviour:
- Reset (synchronous): state IDLE.
  - req_ready=1; done=0; fault=00; rdata=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0.
  - Watchdog counter = 0.
  - Reset mid-transaction aborts it; mem_req drops at that edge; no done is issued.
- Width codes:
  - 000 B, 001 H, 010 W, 100 BU, 101 HU.
  - 011 D and 110 WU only when DATA_W=64.
  - Stores use 000/001/010/(011).
  - Any other code completes with fault=11 and no memory cycle.
- Size SZ in bytes: 1/2/4/8. Offset o = addr[OFS-1:0].
- Misaligned: o mod SZ != 0. Crossing: o+SZ > NB.
- States and transitions:
  - IDLE: on req_valid, latch request.
    - Illegal, or misaligned without the split feature → DONE with the corresponding fault.
    - Otherwise → ACC1.
  - ACC1: mem_req=1.
    - mem_addr = addr with low OFS bits cleared.
    - mem_be = ((1<<SZ)-1) << o, truncated to NB bits.
    - mem_wdata = wdata << 8*o.
    - Hold all outputs stable until mem_ack.
    - On ack: crossing → ACC2; else → DONE.
  - ACC2 (split feature only): mem_addr = previous + NB.
    - mem_be = remaining low lanes ((1<<(o+SZ-NB))-1).
    - mem_wdata = wdata >> 8*(NB-o).
    - On ack → DONE.
  - DONE: done=1 for one cycle, rdata/fault updated → IDLE.
- Load merge: bytes are taken from the lanes starting at o, with the upper bytes from the ACC2 beat. The result is then sign-extended (B/H/W) or zero-extended (BU/HU/WU) to DATA_W.
- Stores leave rdata unchanged; done still pulses.
- mem_ack in the same cycle mem_req first rises is legal and completes that beat.
- mem_ack while mem_req=0 is ignored.
- Latency, ack in the first cycle: aligned access = 3 cycles req→done (accept edge, ACC1, DONE). Split access = 4 cycles.
- Watchdog (MAX_WAIT>0): counts cycles in ACC1/ACC2 without ack; resets on each ack.
  - Reaching MAX_WAIT: drop mem_req, → DONE with fault=10.
  - Load rdata is not updated on a timeout.
- req_valid while req_ready=0 is ignored; it is not queued.

Optional Feature:
- Macro: LSU_MISALIGNED_SPLIT_EN.
- Defined: misaligned accesses are performed.
  - Non-crossing: a single beat with shifted lanes.
  - Crossing: two beats (ACC1, ACC2), merged.
  - fault=01 is never produced.
- Undefined: ACC2 is not built. Any misaligned access goes directly to DONE with fault=01, with no mem_req and no rdata change.

Test Plan:
- DATA_W=32, LB addr 0x103, mem_rdata=0x80FF_1234 acked in 1 cycle → mem_addr 0x100, mem_be 1000, done at cycle 3, rdata 0xFFFF_FF80, fault 00.
- SH addr 0x202, wdata 0x0000_ABCD → mem_be 1100, mem_wdata 0xABCD_0000, mem_we=1. Ack delayed 5 cycles → all outputs stable throughout, done 1 cycle after the ack.
- LW addr 0x301: with LSU_MISALIGNED_SPLIT_EN, word 0x300=0x4433_2211, word 0x304=0x8877_6655 → beats be 1110 then 0001, rdata 0x5544_3322. Without the macro → done with fault=01, no mem_req.
- MAX_WAIT=4, LW with mem_ack never asserted → mem_req high exactly 4 cycles, then done with fault=10 and rdata unchanged.
- DATA_W=32, funct3=011 → fault=11, no mem_req. DATA_W=64, LWU addr 0x4, mem_rdata upper word 0xF000_0001 → rdata 0x0000_0000_F000_0001.
- Reset asserted in ACC1 mid-wait → next edge mem_req=0, req_ready=1, no done pulse. A req_valid pulse while busy is dropped.
